// File: rtl/cla_wide_sequencer_pkg.sv
// Shared types and sizing helpers for the nibble-serial wide adder built on a registered 4-bit CLA.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int NIBBLE_W    = 4;
    localparam int ADD_LAT_DEF = 2;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

    // idx needs at least one bit even for a single-nibble datapath
    function automatic int idx_width(input int width);
        int n;
        n = nib_count(width);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_wide_sequencer_if.sv
// Operand-request and result-return handshakes of the wide adder.
interface cla_wide_sequencer_if #(
    parameter int WIDTH = 16
) ();

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_ovf;

    modport master (
        output start_valid, op_a, op_b, cin, res_ready,
        input  start_ready, res_valid, res_sum, res_cout, res_ovf
    );

    modport slave (
        input  start_valid, op_a, op_b, cin, res_ready,
        output start_ready, res_valid, res_sum, res_cout, res_ovf
    );

endinterface

// File: rtl/cla_4bit.sv
// Registered 4-bit carry-lookahead adder: input register, lookahead logic, output register.
module cla_4bit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s_ff,
    output logic       cout_ff
);

    logic [3:0] a_p0;
    logic [3:0] b_p0;
    logic       cin_p0;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // stage p0: operand register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_p0   <= '0;
            b_p0   <= '0;
            cin_p0 <= 1'b0;
        end else begin
            a_p0   <= a;
            b_p0   <= b;
            cin_p0 <= cin;
        end
    end

    always_comb begin
        g    = a_p0 & b_p0;
        p    = a_p0 ^ b_p0;
        c[0] = cin_p0;
        c[1] = g[0] | (p[0] & cin_p0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_p0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin_p0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin_p0);
    end

    // stage p1: sum/carry register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ff    <= '0;
            cout_ff <= 1'b0;
        end else begin
            s_ff    <= p ^ c[3:0];
            cout_ff <= c[4];
        end
    end

endmodule

// File: rtl/cla_wide_adder_top.sv
// Wide adder: sequencer plus its registered 4-bit CLA stage, exposing only the start/result handshakes.
module cla_wide_adder_top
    import cla_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = ADD_LAT_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    cla_wide_sequencer_if.slave bus
);

    logic [NIBBLE_W-1:0] add_a;
    logic [NIBBLE_W-1:0] add_b;
    logic                add_cin;
    logic [NIBBLE_W-1:0] add_s;
    logic                add_cout;
    logic                reset;

    assign reset = !reset_n;

    cla_wide_sequencer #(
        .WIDTH   (WIDTH),
        .ADD_LAT (ADD_LAT)
    ) u_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    cla_4bit u_cla (
        .clk     (clk),
        .reset   (reset),
        .a       (add_a),
        .b       (add_b),
        .cin     (add_cin),
        .s_ff    (add_s),
        .cout_ff (add_cout)
    );

endmodule

// File: rtl/cla_wide_sequencer.sv
// Feeds a WIDTH-bit add through a registered 4-bit CLA one nibble at a time, chaining the carry.
module cla_wide_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = ADD_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cla_wide_sequencer_if.slave   bus,
    output logic [NIBBLE_W-1:0]   add_a,
    output logic [NIBBLE_W-1:0]   add_b,
    output logic                  add_cin,
    input  logic [NIBBLE_W-1:0]   add_s,
    input  logic                  add_cout
);

    localparam int NIBS  = nib_count(WIDTH);
    localparam int IDX_W = idx_width(WIDTH);
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             valid;
    logic             last;
    logic             lat_done;
    logic             busy;

    function automatic logic [NIBBLE_W-1:0] nib(input logic [WIDTH-1:0] v,
                                                 input logic [IDX_W-1:0] i);
        return v[NIBBLE_W*i +: NIBBLE_W];
    endfunction

    assign last     = (idx == IDX_W'(NIBS - 1));
    assign lat_done = (cnt == CNT_W'(ADD_LAT - 1));
    assign busy     = (state == ISSUE) || (state == CAPTURE);

    // Adder inputs come straight from the captured operands, so they hold through CAPTURE
    assign add_a   = busy ? nib(opa, idx) : '0;
    assign add_b   = busy ? nib(opb, idx) : '0;
    assign add_cin = busy ? carry : 1'b0;

    assign bus.start_ready = (state == IDLE);
    assign bus.res_valid   = valid;
    assign bus.res_sum     = sum;
    assign bus.res_cout    = cout;
    assign bus.res_ovf     = ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start_valid) state_next = ISSUE;
            ISSUE:   if (lat_done)        state_next = CAPTURE;
            CAPTURE: state_next = last ? DONE : ISSUE;
            DONE:    if (bus.res_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        opa   <= bus.op_a;
                        opb   <= bus.op_b;
                        carry <= bus.cin;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                end
                ISSUE: begin
                    if (!lat_done) cnt <= cnt + CNT_W'(1);
                end
                CAPTURE: begin
                    sum[NIBBLE_W*idx +: NIBBLE_W] <= add_s;
                    carry <= add_cout;
                    if (last) begin
                        // MSB-nibble carry leaves the datapath here and never wraps to nibble 0
                        cout  <= add_cout;
                        ovf   <= (opa[WIDTH-1] == opb[WIDTH-1]) && (add_s[NIBBLE_W-1] != opa[WIDTH-1]);
                        valid <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                        cnt <= '0;
                    end
                end
                DONE: begin
                    if (bus.res_ready) valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_wide_sequencer.sv
// Directed bench: sequencer with a CLA stage, plus the packaged top driven in lockstep.
module tb_cla_wide_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_valid;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        res_ready;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_s;
    logic        add_cout;
    int          checks = 0;
    int          errors = 0;

    cla_wide_sequencer_if #(.WIDTH(16)) bus ();
    cla_wide_sequencer_if #(.WIDTH(16)) bus_t ();

    assign bus.start_valid   = start_valid;
    assign bus.op_a          = op_a;
    assign bus.op_b          = op_b;
    assign bus.cin           = cin;
    assign bus.res_ready     = res_ready;
    assign bus_t.start_valid = start_valid;
    assign bus_t.op_a        = op_a;
    assign bus_t.op_b        = op_b;
    assign bus_t.cin         = cin;
    assign bus_t.res_ready   = res_ready;

    cla_wide_sequencer #(.WIDTH(16), .ADD_LAT(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    cla_4bit u_cla (
        .clk     (clk),
        .reset   (!reset_n),
        .a       (add_a),
        .b       (add_b),
        .cin     (add_cin),
        .s_ff    (add_s),
        .cout_ff (add_cout)
    );

    cla_wide_adder_top #(.WIDTH(16), .ADD_LAT(2)) u_top (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
        int n = 0;
        while (!bus.start_ready && n < 50) begin
            tick();
            n++;
        end
        chk("start_ready_wait", {31'd0, bus.start_ready}, 32'd1);
        start_valid = 1'b1;
        op_a = a;
        op_b = b;
        cin  = c;
        tick();
        start_valid = 1'b0;
        op_a = ~a;
        op_b = a ^ b;
        cin  = ~c;
        chk("busy_ready", {31'd0, bus.start_ready}, 32'd0);
    endtask

    task automatic wait_result(input string tag, input logic [15:0] a, input logic [15:0] b);
        int lat = 0;
        while (!bus.res_valid && lat < 50) begin
            if (lat % 3 == 0 && lat < 12) begin
                chk({tag, "_add_a"}, {28'd0, add_a}, {16'd0, a} >> (4 * (lat / 3)) & 32'hF);
                chk({tag, "_add_b"}, {28'd0, add_b}, {16'd0, b} >> (4 * (lat / 3)) & 32'hF);
            end
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd12);
        chk({tag, "_top_valid"}, {31'd0, bus_t.res_valid}, 32'd1);
        chk({tag, "_done_add"}, {23'd0, add_a, add_b, add_cin}, 32'd0);
    endtask

    task automatic check_res(input string tag, input logic [15:0] s, input logic c, input logic o);
        chk({tag, "_sum"}, {16'd0, bus.res_sum}, {16'd0, s});
        chk({tag, "_cout"}, {31'd0, bus.res_cout}, {31'd0, c});
        chk({tag, "_ovf"}, {31'd0, bus.res_ovf}, {31'd0, o});
        chk({tag, "_top"}, {14'd0, bus_t.res_sum, bus_t.res_cout, bus_t.res_ovf}, {14'd0, s, c, o});
    endtask

    task automatic handshake(input string tag, input logic [15:0] s);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, bus.res_valid}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, bus.start_ready}, 32'd1);
        chk({tag, "_sum_kept"}, {16'd0, bus.res_sum}, {16'd0, s});
    endtask

    initial begin
        reset_n     = 1'b0;
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        cin         = 1'b0;
        res_ready   = 1'b0;
        tick();
        chk("rst_start_ready", {31'd0, bus.start_ready}, 32'd1);
        chk("rst_outputs", {13'd0, bus.res_valid, bus.res_sum, bus.res_cout, bus.res_ovf}, 32'd0);
        chk("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: plain add, nibble order and latency
        start_op(16'h1234, 16'h1111, 1'b0);
        wait_result("t1", 16'h1234, 16'h1111);
        check_res("t1", 16'h2345, 1'b0, 1'b0);
        handshake("t1", 16'h2345);

        // 2: carry ripples through every nibble
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_result("t2", 16'hFFFF, 16'h0001);
        check_res("t2", 16'h0000, 1'b1, 1'b0);
        handshake("t2", 16'h0000);

        // 3: signed overflow
        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_result("t3", 16'h7FFF, 16'h0001);
        check_res("t3", 16'h8000, 1'b0, 1'b1);
        handshake("t3", 16'h8000);

        // 4: all ones plus carry-in
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        wait_result("t4", 16'hFFFF, 16'hFFFF);
        check_res("t4", 16'hFFFF, 1'b1, 1'b0);
        handshake("t4", 16'hFFFF);

        // 5: result backpressure with a pending start
        start_op(16'h0123, 16'h0456, 1'b0);
        wait_result("t5", 16'h0123, 16'h0456);
        start_valid = 1'b1;
        op_a = 16'h1111;
        op_b = 16'h2222;
        cin  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("t5_hold_ready", {31'd0, bus.start_ready}, 32'd0);
            check_res("t5_hold", 16'h0579, 1'b0, 1'b0);
        end
        handshake("t5", 16'h0579);
        tick();
        start_valid = 1'b0;
        op_a = 16'hDEAD;
        op_b = 16'hBEEF;
        chk("t5_second_accept", {31'd0, bus.start_ready}, 32'd0);
        wait_result("t5b", 16'h1111, 16'h2222);
        check_res("t5b", 16'h3333, 1'b0, 1'b0);
        handshake("t5b", 16'h3333);

        // 6: reset during nibble 2, then a fresh operation
        start_op(16'h8888, 16'h8888, 1'b0);
        repeat (6) tick();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ready", {31'd0, bus.start_ready}, 32'd1);
        chk("t6_rst_outputs", {13'd0, bus.res_valid, bus.res_sum, bus.res_cout, bus.res_ovf}, 32'd0);
        chk("t6_rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
        chk("t6_rst_top", {13'd0, bus_t.res_valid, bus_t.res_sum, bus_t.res_cout, bus_t.res_ovf}, 32'd0);
        tick();
        reset_n = 1'b1;
        start_op(16'h0F0F, 16'h00F1, 1'b0);
        wait_result("t6", 16'h0F0F, 16'h00F1);
        check_res("t6", 16'h1000, 1'b0, 1'b0);
        handshake("t6", 16'h1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
